icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the IF stage and instruction ROM.
- Produces the hit/ready/instruction signals consumed by flow control and ID.
- Hits are answered combinationally in the request cycle.
- Misses refill a whole line from ROM word-by-word over a req/ready handshake, then deliver the requested word.

---
 rtl/icache_dm_if.sv | 26 ++
 rtl/icache_dm.sv | 116 +++++++++++
 tb/tb_icache_dm.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// Fetch-side and ROM-side signal bundle of the direct-mapped instruction cache.
// The slave modport is the cache itself; the master modport is whatever sits
// around it (IF stage, flow control and the instruction ROM).
interface icache_dm_if;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_jump_i;
   logic        flush_i;
   logic        icache_hit_o;
   logic        icache_ready_o;
   logic [31:0] icache_inst_o;
   logic        rom_req_o;
   logic [31:0] rom_addr_o;
   logic        rom_ready_i;
   logic [31:0] rom_data_i;

   modport master (
      output if_req_i, if_addr_i, if_jump_i, flush_i, rom_ready_i, rom_data_i,
      input  icache_hit_o, icache_ready_o, icache_inst_o, rom_req_o, rom_addr_o
   );

   modport slave (
      input  if_req_i, if_addr_i, if_jump_i, flush_i, rom_ready_i, rom_data_i,
      output icache_hit_o, icache_ready_o, icache_inst_o, rom_req_o, rom_addr_o
   );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. Hits answer in the request
// cycle. A miss refills the whole line from ROM starting at word 0, then
// spends one RESP cycle delivering the requested word (unless a jump
// arrived during the refill, in which case the delivery is dropped).
module icache_dm #(
   parameter int INDEX_W = 4,
   parameter int WORD_W  = 2
) (
   input logic        clk,
   input logic        rst_n,
   icache_dm_if.slave bus
);

   localparam int TAG_W  = 32 - INDEX_W - WORD_W - 2;
   localparam int LINES  = 1 << INDEX_W;
   localparam int WORDS  = 1 << WORD_W;
   localparam int TAG_LO = INDEX_W + WORD_W + 2;

   typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

   state_t              state;
   logic [31:2]         miss_addr;
   logic [WORD_W-1:0]   cnt;
   logic                drop;
   logic                flushed;
   logic                rom_req;
   logic [LINES-1:0]    valid;

   logic [31:0]         data_mem [LINES*WORDS];
   logic [TAG_W-1:0]    tag_mem  [LINES];

   logic [WORD_W-1:0]   req_word;
   logic [INDEX_W-1:0]  req_index;
   logic [TAG_W-1:0]    req_tag;
   logic [WORD_W-1:0]   miss_word;
   logic [INDEX_W-1:0]  miss_index;
   logic [TAG_W-1:0]    miss_tag;
   logic                lookup_hit;
   logic                accept;
   logic                last_word;
   logic                resp_valid;

   assign req_word   = bus.if_addr_i[WORD_W+1:2];
   assign req_index  = bus.if_addr_i[TAG_LO-1:WORD_W+2];
   assign req_tag    = bus.if_addr_i[31:TAG_LO];
   assign miss_word  = miss_addr[WORD_W+1:2];
   assign miss_index = miss_addr[TAG_LO-1:WORD_W+2];
   assign miss_tag   = miss_addr[31:TAG_LO];

   assign lookup_hit = (state == IDLE) && bus.if_req_i && valid[req_index]
                       && (tag_mem[req_index] == req_tag);
   assign accept     = (state == REFILL) && bus.rom_ready_i;
   assign last_word  = accept && (cnt == WORD_W'(WORDS - 1));
   assign resp_valid = (state == RESP) && !drop;

   // Control FSM: miss detection, refill sequencing, drop/flush bookkeeping
   // and the valid bits. A flush seen at any point of the refill keeps the
   // refilled line from being marked valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         miss_addr <= '0;
         cnt       <= '0;
         drop      <= 1'b0;
         flushed   <= 1'b0;
         rom_req   <= 1'b0;
         valid     <= '0;
      end else begin
         if (bus.flush_i) valid <= '0;
         case (state)
            IDLE: begin
               if (bus.if_req_i && !lookup_hit) begin
                  miss_addr <= bus.if_addr_i[31:2];
                  cnt       <= '0;
                  drop      <= 1'b0;
                  flushed   <= 1'b0;
                  rom_req   <= 1'b1;
                  state     <= REFILL;
               end
            end
            REFILL: begin
               if (bus.if_jump_i) drop <= 1'b1;
               if (bus.flush_i) flushed <= 1'b1;
               if (accept) cnt <= cnt + 1'b1;
               if (last_word) begin
                  rom_req <= 1'b0;
                  state   <= RESP;
                  if (!bus.flush_i && !flushed) valid[miss_index] <= 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               rom_req <= 1'b0;
            end
         endcase
      end
   end

   // Data and tag storage, written only by accepted ROM words; not reset.
   always_ff @(posedge clk) begin
      if (accept) data_mem[{miss_index, cnt}] <= bus.rom_data_i;
      if (last_word) tag_mem[miss_index] <= miss_tag;
   end

   assign bus.icache_hit_o   = lookup_hit;
   assign bus.icache_ready_o = lookup_hit | resp_valid;
   assign bus.icache_inst_o  = lookup_hit ? data_mem[{req_index, req_word}] :
                               resp_valid ? data_mem[{miss_index, miss_word}] :
                               32'h0;
   assign bus.rom_req_o      = rom_req;
   assign bus.rom_addr_o     = rom_req ? {miss_addr[31:WORD_W+2], cnt, 2'b00} : 32'h0;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm. A line-level model (valid/tag per line)
// decides hit or miss; the ROM is a pure function of the word address, so the
// expected instruction for any address is known without consulting the DUT.
module tb_icache_dm;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   icache_dm_if bus();

   icache_dm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int testsRun = 0;
   int testsFailed = 0;

   bit          modelValid [16];
   logic [23:0] modelTag   [16];

   function automatic logic [31:0] romWord(input logic [31:0] a);
      if (a[31:4] == 28'h4) return 32'hA0 + {30'b0, a[3:2]};
      return (a ^ 32'hDEAD_0000) * 32'd3 + 32'h11;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < 16; i++) modelValid[i] = 1'b0;
   endtask

   // One fetch: hit check, or a full refill with optional jump/flush during a
   // chosen word and a number of ROM wait states per word (negative = random).
   task automatic applyStimulus(input logic [31:0] addr, input int jumpWord,
                                input int flushWord, input int waitSel);
      logic [31:0] wordAddr;
      logic [31:0] lineBase;
      logic [3:0]  idx;
      logic [23:0] tag;
      bit          expHit;
      bit          dropped;
      bit          flushed;
      int          waits;
      wordAddr = {addr[31:2], 2'b00};
      lineBase = {addr[31:4], 4'h0};
      idx      = addr[7:4];
      tag      = addr[31:8];
      @(negedge clk);
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
      bus.if_jump_i = ($urandom_range(3, 0) == 0);
      #2;
      expHit = modelValid[idx] && (modelTag[idx] == tag);
      checkOutput("lookupHit", {31'b0, bus.icache_hit_o}, {31'b0, expHit});
      checkOutput("lookupReady", {31'b0, bus.icache_ready_o}, {31'b0, expHit});
      checkOutput("lookupInst", bus.icache_inst_o, expHit ? romWord(wordAddr) : 32'h0);
      checkOutput("idleRomReq", {31'b0, bus.rom_req_o}, 32'h0);
      if (expHit) begin
         @(posedge clk);
         #1;
         bus.if_req_i  = 1'b0;
         bus.if_jump_i = 1'b0;
         return;
      end
      dropped = 1'b0;
      flushed = 1'b0;
      for (int k = 0; k < 4; k++) begin
         waits = (waitSel >= 0) ? waitSel : int'($urandom_range(4, 0));
         for (int c = 0; c <= waits; c++) begin
            @(negedge clk);
            bus.if_req_i    = $urandom_range(1, 0) == 1;
            bus.if_addr_i   = $urandom;
            bus.if_jump_i   = (jumpWord == k) && (c == 0);
            bus.flush_i     = (flushWord == k) && (c == 0);
            bus.rom_ready_i = (c == waits);
            bus.rom_data_i  = (c == waits) ? romWord(lineBase + 32'(k * 4)) : $urandom;
            if (bus.if_jump_i) dropped = 1'b1;
            if (bus.flush_i) flushed = 1'b1;
            #2;
            checkOutput("refillRomReq", {31'b0, bus.rom_req_o}, 32'h1);
            checkOutput("refillRomAddr", bus.rom_addr_o, lineBase + 32'(k * 4));
            checkOutput("refillHit", {31'b0, bus.icache_hit_o}, 32'h0);
            checkOutput("refillReady", {31'b0, bus.icache_ready_o}, 32'h0);
            checkOutput("refillInst", bus.icache_inst_o, 32'h0);
         end
      end
      @(negedge clk);
      bus.if_req_i    = 1'b0;
      bus.if_jump_i   = 1'b0;
      bus.flush_i     = 1'b0;
      bus.rom_ready_i = 1'b0;
      #2;
      checkOutput("respRomReq", {31'b0, bus.rom_req_o}, 32'h0);
      checkOutput("respHit", {31'b0, bus.icache_hit_o}, 32'h0);
      checkOutput("respReady", {31'b0, bus.icache_ready_o}, {31'b0, !dropped});
      checkOutput("respInst", bus.icache_inst_o, dropped ? 32'h0 : romWord(wordAddr));
      if (flushed) begin
         clearModel();
      end else begin
         modelValid[idx] = 1'b1;
         modelTag[idx]   = tag;
      end
      @(posedge clk);
   endtask

   // Flush in IDLE; a lookup in the same cycle still sees the old valid bits.
   task automatic applyFlush(input logic [31:0] addr);
      bit expHit;
      expHit = modelValid[addr[7:4]] && (modelTag[addr[7:4]] == addr[31:8]);
      @(negedge clk);
      bus.flush_i   = 1'b1;
      bus.if_req_i  = expHit;
      bus.if_addr_i = addr;
      #2;
      checkOutput("flushLookupHit", {31'b0, bus.icache_hit_o}, {31'b0, expHit});
      checkOutput("flushLookupInst", bus.icache_inst_o,
                  expHit ? romWord({addr[31:2], 2'b00}) : 32'h0);
      @(posedge clk);
      #1;
      bus.flush_i  = 1'b0;
      bus.if_req_i = 1'b0;
      clearModel();
   endtask

   // Reset asserted in the middle of a refill must drop rom_req_o at once.
   task automatic applyReset(input logic [31:0] addr);
      @(negedge clk);
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
      #2;
      checkOutput("preResetMiss", {31'b0, bus.icache_hit_o}, 32'h0);
      @(negedge clk);
      bus.if_req_i = 1'b0;
      #2;
      checkOutput("preResetRomReq", {31'b0, bus.rom_req_o}, 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncResetRomReq", {31'b0, bus.rom_req_o}, 32'h0);
      checkOutput("asyncResetRomAddr", bus.rom_addr_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      clearModel();
   endtask

   // Directed test-plan sequence followed by randomized fetches.
   initial begin
      logic [31:0] addr;
      int jw;
      int fw;
      bus.if_req_i    = 1'b0;
      bus.if_addr_i   = 32'h0;
      bus.if_jump_i   = 1'b0;
      bus.flush_i     = 1'b0;
      bus.rom_ready_i = 1'b0;
      bus.rom_data_i  = 32'h0;
      clearModel();
      repeat (3) @(negedge clk);
      #2;
      checkOutput("resetRomReq", {31'b0, bus.rom_req_o}, 32'h0);
      checkOutput("resetReady", {31'b0, bus.icache_ready_o}, 32'h0);
      checkOutput("resetInst", bus.icache_inst_o, 32'h0);
      rst_n = 1'b1;

      applyStimulus(32'h0000_0040, -1, -1, 0);
      applyStimulus(32'h0000_0048, -1, -1, 0);
      applyStimulus(32'h0000_0140, -1, -1, 0);
      applyStimulus(32'h0000_0040, -1, -1, 0);
      applyStimulus(32'h0000_0208, -1, -1, 3);
      applyStimulus(32'h0000_0204, -1, -1, 0);
      applyStimulus(32'h0000_0300, 1, -1, 0);
      applyStimulus(32'h0000_030C, -1, -1, 0);
      applyFlush(32'h0000_0304);
      applyStimulus(32'h0000_0304, -1, -1, 0);
      applyStimulus(32'h0000_0500, -1, 2, 1);
      applyStimulus(32'h0000_0500, -1, -1, 0);
      applyStimulus(32'h0000_0504, -1, -1, 0);
      applyReset(32'h0000_0640);
      applyStimulus(32'h0000_0504, -1, -1, 0);
      applyStimulus(32'h0000_0040, -1, -1, 0);

      for (int n = 0; n < 200; n++) begin
         addr = {22'b0, 2'($urandom_range(3, 0)), 4'($urandom), 2'($urandom), 2'($urandom)};
         jw = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
         fw = ($urandom_range(15, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
         if ($urandom_range(19, 0) == 0) applyFlush(addr);
         applyStimulus(addr, jw, fw, -1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
